// File: rtl/t07_mmio_router.sv
// MMIO router: decodes a CPU request into memory, register or TFT access and waits for completion.
// Optional abort-on-timeout is enabled by defining T07_MMIO_TIMEOUT_EN.
module t07_mmio_router #(
  parameter int unsigned FETCH_HI       = 1024,
  parameter int unsigned REG_HI         = 1056,
  parameter int unsigned DMEM_HI        = 1792,
  parameter int unsigned TFT_HI         = 2048,
  parameter logic [7:0]  MEM_PREFIX     = 8'h33,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_rwi,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_fetch,
  output logic [1:0]  rwi_out,
  output logic [31:0] addr_out,
  output logic [31:0] writeData_out,
  input  logic [31:0] ExtData_in,
  input  logic        busy_o,
  output logic        ri_out,
  output logic [4:0]  addr_outREG,
  input  logic [31:0] regData_in,
  input  logic        ack_REG,
  output logic        wi_out,
  output logic [31:0] addr_outTFT,
  output logic [31:0] writeData_outTFT,
  input  logic        ack_TFT
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {TGT_NONE, TGT_MEM, TGT_REG, TGT_TFT} tgt_t;

  state_t      state, state_nxt;
  tgt_t        dec_tgt, tgt_p0;
  logic        dec_fetch;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [1:0]  rwi_p0;
  logic        seen_busy;
  logic        is_rd, is_wr, accept;
  logic        sel_busy, done, timeout;

  assign is_rd  = (req_rwi == 2'b10);
  assign is_wr  = (req_rwi == 2'b01);
  assign accept = (state == ST_IDLE) && req_valid && (is_rd || is_wr);

  // Address/direction decode; anything not matched stays TGT_NONE and is answered with an error.
  always_comb begin
    dec_tgt   = TGT_NONE;
    dec_fetch = 1'b0;
    if (req_addr <= FETCH_HI) begin
      if (is_rd) begin
        dec_tgt   = TGT_MEM;
        dec_fetch = 1'b1;
      end
    end else if (req_addr <= REG_HI) begin
      if (is_rd) dec_tgt = TGT_REG;
    end else if (req_addr <= DMEM_HI) begin
      if (is_rd || is_wr) dec_tgt = TGT_MEM;
    end else if (req_addr < TFT_HI) begin
      if (is_wr) dec_tgt = TGT_TFT;
    end
  end

  always_comb begin
    sel_busy = 1'b0;
    case (tgt_p0)
      TGT_MEM: sel_busy = busy_o;
      TGT_REG: sel_busy = ack_REG;
      TGT_TFT: sel_busy = ack_TFT;
      default: sel_busy = 1'b0;
    endcase
  end

  assign done = (state == ST_WAIT) && seen_busy && !sel_busy;

`ifdef T07_MMIO_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timeout = (state == ST_WAIT) && !done && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  wait_cnt <= 8'd0;
    else if (accept)            wait_cnt <= 8'd0;
    else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (dec_tgt == TGT_NONE) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (done || timeout) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and response capture.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tgt_p0    <= TGT_NONE;
      addr_p0   <= 32'd0;
      wdata_p0  <= 32'd0;
      rwi_p0    <= 2'b11;
      seen_busy <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      rsp_fetch <= 1'b0;
    end else if (accept) begin
      tgt_p0    <= dec_tgt;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
      rwi_p0    <= req_rwi;
      seen_busy <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= (dec_tgt == TGT_NONE);
      rsp_fetch <= dec_fetch;
    end else if (state == ST_WAIT) begin
      if (sel_busy) seen_busy <= 1'b1;
      if (done) begin
        if (rwi_p0 == 2'b10 && tgt_p0 == TGT_MEM)      rsp_rdata <= ExtData_in;
        else if (rwi_p0 == 2'b10 && tgt_p0 == TGT_REG) rsp_rdata <= regData_in;
        else                                           rsp_rdata <= 32'd0;
      end else if (timeout) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= 32'd0;
      end
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // Target strobes exist only while waiting; everything else idles at zero / 2'b11.
  always_comb begin
    rwi_out          = 2'b11;
    addr_out         = 32'd0;
    writeData_out    = 32'd0;
    ri_out           = 1'b0;
    addr_outREG      = 5'd0;
    wi_out           = 1'b0;
    addr_outTFT      = 32'd0;
    writeData_outTFT = 32'd0;
    if (state == ST_WAIT) begin
      case (tgt_p0)
        TGT_MEM: begin
          rwi_out  = rwi_p0;
          addr_out = {MEM_PREFIX, addr_p0[23:0]};
          if (rwi_p0 == 2'b01) writeData_out = wdata_p0;
        end
        TGT_REG: begin
          ri_out      = 1'b1;
          addr_outREG = addr_p0[4:0];
        end
        TGT_TFT: begin
          wi_out           = 1'b1;
          addr_outTFT      = addr_p0;
          writeData_outTFT = wdata_p0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t07_mmio_router.sv
// Randomized/directed bench for t07_mmio_router with a window-rule reference model.
module tb_t07_mmio_router;

  localparam int unsigned FETCH_HI = 1024;
  localparam int unsigned REG_HI   = 1056;
  localparam int unsigned DMEM_HI  = 1792;
  localparam int unsigned TFT_HI   = 2048;
  localparam int NONE = 0, MEMT = 1, REGT = 2, TFTT = 3;

  logic        clk, nrst;
  logic        req_valid, req_ready;
  logic [1:0]  req_rwi;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, rsp_fetch;
  logic [31:0] rsp_rdata;
  logic [1:0]  rwi_out;
  logic [31:0] addr_out, writeData_out, ExtData_in;
  logic        busy_o;
  logic        ri_out;
  logic [4:0]  addr_outREG;
  logic [31:0] regData_in;
  logic        ack_REG;
  logic        wi_out;
  logic [31:0] addr_outTFT, writeData_outTFT;
  logic        ack_TFT;

  int n_chk  = 0;
  int n_fail = 0;

  t07_mmio_router dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rwi(req_rwi),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_fetch(rsp_fetch),
    .rwi_out(rwi_out), .addr_out(addr_out), .writeData_out(writeData_out),
    .ExtData_in(ExtData_in), .busy_o(busy_o),
    .ri_out(ri_out), .addr_outREG(addr_outREG), .regData_in(regData_in), .ack_REG(ack_REG),
    .wi_out(wi_out), .addr_outTFT(addr_outTFT), .writeData_outTFT(writeData_outTFT),
    .ack_TFT(ack_TFT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the window/direction rules.
  function automatic int tgt_of(input logic [1:0] rwi, input logic [31:0] a);
    bit rd, wr;
    rd = (rwi == 2'b10);
    wr = (rwi == 2'b01);
    if (a <= FETCH_HI) return rd ? MEMT : NONE;
    if (a <= REG_HI)   return rd ? REGT : NONE;
    if (a <= DMEM_HI)  return (rd || wr) ? MEMT : NONE;
    if (a < TFT_HI)    return wr ? TFTT : NONE;
    return NONE;
  endfunction

  task automatic check_strobes(input string tag, input int t, input logic [1:0] rwi,
                               input logic [31:0] a, input logic [31:0] d);
    logic [31:0] maddr;
    maddr = {8'h33, a[23:0]};
    chk({tag, ".rwi_out"},   rwi_out,          (t == MEMT) ? {30'd0, rwi} : 32'd3);
    chk({tag, ".addr_out"},  addr_out,         (t == MEMT) ? maddr : 32'd0);
    chk({tag, ".wdata_out"}, writeData_out,    (t == MEMT && rwi == 2'b01) ? d : 32'd0);
    chk({tag, ".ri_out"},    ri_out,           (t == REGT) ? 32'd1 : 32'd0);
    chk({tag, ".addr_reg"},  addr_outREG,      (t == REGT) ? {27'd0, a[4:0]} : 32'd0);
    chk({tag, ".wi_out"},    wi_out,           (t == TFTT) ? 32'd1 : 32'd0);
    chk({tag, ".addr_tft"},  addr_outTFT,      (t == TFTT) ? a : 32'd0);
    chk({tag, ".wdata_tft"}, writeData_outTFT, (t == TFTT) ? d : 32'd0);
  endtask

  // Selected target gets v; the other busy lines get noise.
  task automatic set_busy(input int t, input logic v);
    busy_o  = (t == MEMT) ? v : 1'($urandom);
    ack_REG = (t == REGT) ? v : 1'($urandom);
    ack_TFT = (t == TFTT) ? v : 1'($urandom);
    ExtData_in = $urandom;
    regData_in = $urandom;
  endtask

  // Called just after a rising edge while IDLE; returns just after a rising edge while IDLE.
  task automatic txn(input logic [1:0] rwi, input logic [31:0] a, input logic [31:0] d,
                     input int pre, input int hi);
    int t;
    logic [31:0] exp_rd;
    logic exp_fetch;
    t = tgt_of(rwi, a);
    req_valid = 1'b1; req_rwi = rwi; req_addr = a; req_wdata = d;
    @(negedge clk);
    chk("accept.ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'($urandom); req_rwi = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (t == NONE) begin
      req_valid = 1'b0;
      @(negedge clk);
      chk("illegal.rsp_valid", rsp_valid, 1);
      chk("illegal.rsp_err", rsp_err, 1);
      chk("illegal.rsp_fetch", rsp_fetch, 0);
      check_strobes("illegal", NONE, 2'b11, 0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("illegal.after_valid", rsp_valid, 0);
      chk("illegal.after_ready", req_ready, 1);
      chk("illegal.err_hold", rsp_err, 1);
      @(posedge clk); #1;
      return;
    end
    exp_fetch = (a <= FETCH_HI);
    for (int i = 0; i < pre + hi; i++) begin
      set_busy(t, (i >= pre));
      req_valid = 1'($urandom);
      @(negedge clk);
      check_strobes("wait", t, rwi, a, d);
      chk("wait.rsp_valid", rsp_valid, 0);
      chk("wait.ready", req_ready, 0);
      @(posedge clk); #1;
    end
    set_busy(t, 1'b0);
    req_valid = 1'b0;
    exp_rd = (rwi == 2'b10) ? ((t == MEMT) ? ExtData_in : regData_in) : 32'd0;
    @(negedge clk);
    check_strobes("done", t, rwi, a, d);
    chk("done.rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    set_busy(NONE, 1'b0);
    @(negedge clk);
    chk("resp.rsp_valid", rsp_valid, 1);
    chk("resp.rdata", rsp_rdata, exp_rd);
    chk("resp.err", rsp_err, 0);
    chk("resp.fetch", rsp_fetch, exp_fetch);
    check_strobes("resp", NONE, 2'b11, 0, 0);
    @(posedge clk); #1;
    busy_o = 0; ack_REG = 0; ack_TFT = 0;
    @(negedge clk);
    chk("post.rsp_valid", rsp_valid, 0);
    chk("post.ready", req_ready, 1);
    chk("post.rdata_hold", rsp_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0:  return 32'd0;
      1:  return FETCH_HI;
      2:  return FETCH_HI + 1;
      3:  return REG_HI;
      4:  return REG_HI + 1;
      5:  return DMEM_HI;
      6:  return DMEM_HI + 1;
      7:  return TFT_HI - 1;
      8:  return TFT_HI;
      9:  return $urandom;
      default: return 32'($urandom_range(0, TFT_HI + 64));
    endcase
  endfunction

  initial begin
    int waits;
    bit got;
    nrst = 1'b0; req_valid = 0; req_rwi = 0; req_addr = 0; req_wdata = 0;
    ExtData_in = 0; regData_in = 0; busy_o = 0; ack_REG = 0; ack_TFT = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_strobes("reset", NONE, 2'b11, 0, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_err", rsp_err, 0);
    chk("reset.rsp_fetch", rsp_fetch, 0);
    chk("reset.rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("reset.ready", req_ready, 1);
    @(posedge clk); #1;

    // Directed cases from the requirement examples.
    txn(2'b10, 32'h0000_0010, 32'h0, 1, 2);
    txn(2'b01, 32'h0000_0500, 32'hDEAD_BEEF, 0, 2);
    txn(2'b10, 32'h0000_0410, 32'h0, 0, 1);
    txn(2'b01, 32'h0000_0400, 32'h1234_5678, 0, 1);
    txn(2'b10, 32'h0000_0720, 32'h0, 0, 1);

    // Unsupported rwi codes are not accepted.
    req_valid = 1'b1; req_rwi = 2'b00; req_addr = 32'd1500;
    @(negedge clk); chk("rwi00.ready", req_ready, 1);
    @(posedge clk); #1; req_rwi = 2'b11;
    @(negedge clk); chk("rwi11.ready", req_ready, 1); chk("rwi00.no_rsp", rsp_valid, 0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); chk("rwi11.no_rsp", rsp_valid, 0); check_strobes("rwi11", NONE, 2'b11, 0, 0);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++)
      txn(2'($urandom_range(1, 2)), pick_addr(), $urandom, $urandom_range(0, 2), $urandom_range(1, 4));

    // Reset while a data-memory read is waiting.
    req_valid = 1'b1; req_rwi = 2'b10; req_addr = 32'd1500;
    @(posedge clk); #1; req_valid = 1'b0; busy_o = 1'b1;
    @(negedge clk); chk("rstwait.rwi_out", rwi_out, 2'b10);
    #2 nrst = 1'b0;
    #1;
    check_strobes("rstwait", NONE, 2'b11, 0, 0);
    chk("rstwait.rsp_valid", rsp_valid, 0);
    chk("rstwait.rsp_err", rsp_err, 0);
    chk("rstwait.rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1; nrst = 1'b1; busy_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rstwait.no_rsp", rsp_valid, 0); chk("rstwait.ready", req_ready, 1);
      @(posedge clk); #1;
    end
    txn(2'b10, 32'd1600, 32'h0, 0, 2);

    // TFT write with ack stuck high.
    req_valid = 1'b1; req_rwi = 2'b01; req_addr = 32'd1800; req_wdata = 32'hCAFE_0001;
    @(posedge clk); #1; req_valid = 1'b0; ack_TFT = 1'b1;
    waits = 0; got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
      waits++;
      @(posedge clk); #1;
    end
`ifdef T07_MMIO_TIMEOUT_EN
    chk("timeout.got", got, 1);
    chk("timeout.waits", waits, 255);
    chk("timeout.err", rsp_err, 1);
    chk("timeout.rdata", rsp_rdata, 0);
    chk("timeout.wi_out", wi_out, 0);
    @(posedge clk); #1; ack_TFT = 1'b0;
    @(negedge clk); chk("timeout.ready", req_ready, 1);
    @(posedge clk); #1;
`else
    chk("stuck.got", got, 0);
    ack_TFT = 1'b0;
    @(negedge clk);
    chk("stuck.ready", req_ready, 0);
    chk("stuck.wi_out", wi_out, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stuck.rsp_valid", rsp_valid, 1);
    chk("stuck.err", rsp_err, 0);
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
